nbody_pair_scheduler: RTL and testbench

Sequences one acceleration pass of the 2x2 3D systolic n-body array. Enumerates every unordered body pair (i<j) once, feeds two array lanes with one cycle of systolic skew, and emits the matching accumulate enables and indices for the array's right (OPR) and down (OPD) outputs. It sits between the body-state memory, which the feed indices address, and the per-body acceleration accumulators.

---
 rtl/nbody_sched_pkg.sv | 24 ++
 rtl/nbody_pair_enum.sv | 60 ++++++
 rtl/nbody_pair_scheduler.sv | 163 ++++++++++++++++
 tb/tb_nbody_pair_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbody_sched_pkg.sv
// Shared types and helpers for the n-body pair scheduler.
// State codes, the pair record carried through the skew/delay stages, and the pair count.
package nbody_sched_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Widest body index the pair record can carry; narrower indices are zero-extended.
  localparam int unsigned MAX_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] i;
    logic [MAX_IDX_W-1:0] j;
  } pair_t;

  function automatic int unsigned pair_count(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/nbody_pair_enum.sv
// (i,j) pair enumerator for i<j in lexicographic order.
// Exposes the current pair and its successor; advancing moves forward by two pairs.
module nbody_pair_enum
  import nbody_sched_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned IDX_W    = $clog2(N_BODIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] i_nxt,
  output logic [IDX_W-1:0] j_nxt
);

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
  } idx_pair_t;

  // Past the last pair the result wraps; callers mask it with a valid flag.
  function automatic idx_pair_t next_pair(input idx_pair_t p);
    idx_pair_t n;
    if (p.j == IDX_W'(N_BODIES - 1)) begin
      n.i = p.i + IDX_W'(1);
      n.j = p.i + IDX_W'(2);
    end else begin
      n.i = p.i;
      n.j = p.j + IDX_W'(1);
    end
    return n;
  endfunction

  idx_pair_t cur_q, step1, step2;

  always_comb begin
    step1 = next_pair(cur_q);
    step2 = next_pair(step1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
    end else if (load) begin
      cur_q.i <= '0;
      cur_q.j <= IDX_W'(1);
    end else if (advance) begin
      cur_q <= step2;
    end
  end

  assign i     = cur_q.i;
  assign j     = cur_q.j;
  assign i_nxt = step1.i;
  assign j_nxt = step1.j;

endmodule

// File: rtl/nbody_pair_scheduler.sv
// Sequences one acceleration pass of the 2x2 systolic n-body array: feeds body pairs on two
// skewed lanes and raises the matching accumulate enables LAT cycles after each injection.
module nbody_pair_scheduler
  import nbody_sched_pkg::*;
#(
  parameter int unsigned N_BODIES = 4,
  parameter int unsigned IDX_W    = $clog2(N_BODIES),
  parameter int unsigned LAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             acc_clear,
  output logic             feed_v0,
  output logic             feed_v1,
  output logic [IDX_W-1:0] feed_i0,
  output logic [IDX_W-1:0] feed_j0,
  output logic [IDX_W-1:0] feed_i1,
  output logic [IDX_W-1:0] feed_j1,
  output logic             acc_r0,
  output logic             acc_r1,
  output logic             acc_d0,
  output logic             acc_d1,
  output logic [IDX_W-1:0] acc_ri0,
  output logic [IDX_W-1:0] acc_ri1,
  output logic [IDX_W-1:0] acc_di0,
  output logic [IDX_W-1:0] acc_di1
);

  localparam int unsigned P     = pair_count(N_BODIES);
  localparam int unsigned F     = (P + 1) / 2;
  localparam bit          P_ODD = (P % 2) == 1;
  localparam int unsigned CNT_W = 16;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ei, ej, ei_nxt, ej_nxt;
  pair_t            lane0, lane1_d, lane1_q;
  pair_t            d0_out, d1_out;

  nbody_pair_enum #(
    .N_BODIES(N_BODIES),
    .IDX_W   (IDX_W)
  ) u_enum (
    .clk    (clk),
    .rst    (rst),
    .load   (state_q == S_CLEAR),
    .advance(state_q == S_FEED),
    .i      (ei),
    .j      (ej),
    .i_nxt  (ei_nxt),
    .j_nxt  (ej_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == CNT_W'(F - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(LAT)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane 0 takes pair 2k now; pair 2k+1 is captured for lane 1 one cycle later.
  always_comb begin
    lane0   = '0;
    lane1_d = '0;
    if (state_q == S_FEED) begin
      lane0.valid = 1'b1;
      lane0.i     = MAX_IDX_W'(ei);
      lane0.j     = MAX_IDX_W'(ej);
      if (!P_ODD || cnt_q != CNT_W'(F - 1)) begin
        lane1_d.valid = 1'b1;
        lane1_d.i     = MAX_IDX_W'(ei_nxt);
        lane1_d.j     = MAX_IDX_W'(ej_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lane1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane1_q <= lane1_d;
    end
  end

  for (genvar s = 0; s < LAT; s++) begin : g_dly
    pair_t q0, q1, in0, in1;
    if (s == 0) begin : g_head
      assign in0 = lane0;
      assign in1 = lane1_q;
    end else begin : g_tail
      assign in0 = g_dly[s-1].q0;
      assign in1 = g_dly[s-1].q1;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        q0 <= '0;
        q1 <= '0;
      end else begin
        q0 <= in0;
        q1 <= in1;
      end
    end
  end

  assign d0_out = g_dly[LAT-1].q0;
  assign d1_out = g_dly[LAT-1].q1;

  // Index bits above IDX_W are always zero.
  logic unused_hi;
  assign unused_hi = ^{d0_out, d1_out, lane0, lane1_q};

  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign acc_clear = state_q == S_CLEAR;

  assign feed_v0 = lane0.valid;
  assign feed_i0 = lane0.i[IDX_W-1:0];
  assign feed_j0 = lane0.j[IDX_W-1:0];
  assign feed_v1 = lane1_q.valid;
  assign feed_i1 = lane1_q.i[IDX_W-1:0];
  assign feed_j1 = lane1_q.j[IDX_W-1:0];

  // OPD already carries the reaction sign, so both enables just add.
  assign acc_r0  = d0_out.valid;
  assign acc_d0  = d0_out.valid;
  assign acc_ri0 = d0_out.i[IDX_W-1:0];
  assign acc_di0 = d0_out.j[IDX_W-1:0];
  assign acc_r1  = d1_out.valid;
  assign acc_d1  = d1_out.valid;
  assign acc_ri1 = d1_out.i[IDX_W-1:0];
  assign acc_di1 = d1_out.j[IDX_W-1:0];

endmodule

// File: tb/tb_nbody_pair_scheduler.sv
// Bench for nbody_pair_scheduler: four configurations (N=4/3/2 with LAT=1, N=5 with LAT=2),
// cycle-by-cycle trace scoreboard plus a physics golden check on accumulated accelerations.
module tb_nbody_pair_scheduler;

  localparam int NI = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       clr;
    logic       v0;
    logic       v1;
    logic       r0;
    logic       r1;
    logic       d0;
    logic       d1;
    logic [2:0] i0;
    logic [2:0] j0;
    logic [2:0] i1;
    logic [2:0] j1;
    logic [2:0] ri0;
    logic [2:0] ri1;
    logic [2:0] di0;
    logic [2:0] di1;
  } obs_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst;
  logic [NI-1:0] start;
  obs_t          obs [NI];
  obs_t          exp_q [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NB = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 2 : 5;
    localparam int unsigned LT = (g == 3) ? 2 : 1;
    localparam int unsigned W  = $clog2(NB);
    logic         busy, done, clr, v0, v1, r0, r1, d0, d1;
    logic [W-1:0] i0, j0, i1, j1, ri0, ri1, di0, di1;

    nbody_pair_scheduler #(
      .N_BODIES(NB),
      .IDX_W   (W),
      .LAT     (LT)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .busy     (busy),
      .done     (done),
      .acc_clear(clr),
      .feed_v0  (v0),
      .feed_v1  (v1),
      .feed_i0  (i0),
      .feed_j0  (j0),
      .feed_i1  (i1),
      .feed_j1  (j1),
      .acc_r0   (r0),
      .acc_r1   (r1),
      .acc_d0   (d0),
      .acc_d1   (d1),
      .acc_ri0  (ri0),
      .acc_ri1  (ri1),
      .acc_di0  (di0),
      .acc_di1  (di1)
    );

    assign obs[g] = {busy, done, clr, v0, v1, r0, r1, d0, d1, 3'(i0), 3'(j0), 3'(i1), 3'(j1),
                     3'(ri0), 3'(ri1), 3'(di0), 3'(di1)};
  end

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : (k == 2) ? 2 : 5;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int trace_len(input int n, input int lat);
    int f;
    f = (n * (n - 1) / 2 + 1) / 2;
    return f + lat + 4;
  endfunction

  // Expected outputs for cycles 0..len-1 of a pass whose start is driven in cycle 0.
  function automatic void build_trace(input int n, input int lat);
    int   pi [$];
    int   pj [$];
    int   p, f, len, q, cl;
    obs_t e;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++) begin
        pi.push_back(i);
        pj.push_back(j);
      end
    p   = pi.size();
    f   = (p + 1) / 2;
    len = f + lat + 4;
    for (int c = 0; c < len; c++) begin
      e      = '0;
      e.busy = (c >= 1) && (c <= f + 3 + lat);
      e.clr  = (c == 1);
      e.done = (c == f + 3 + lat);
      if (c >= 2 && c <= f + 1) begin
        q = 2 * (c - 2);
        e.v0 = 1'b1; e.i0 = 3'(pi[q]); e.j0 = 3'(pj[q]);
      end
      if (c >= 3 && c <= f + 2) begin
        q = 2 * (c - 3) + 1;
        if (q < p) begin
          e.v1 = 1'b1; e.i1 = 3'(pi[q]); e.j1 = 3'(pj[q]);
        end
      end
      cl = c - lat;
      if (cl >= 2 && cl <= f + 1) begin
        q = 2 * (cl - 2);
        e.r0 = 1'b1; e.d0 = 1'b1; e.ri0 = 3'(pi[q]); e.di0 = 3'(pj[q]);
      end
      if (cl >= 3 && cl <= f + 2) begin
        q = 2 * (cl - 3) + 1;
        if (q < p) begin
          e.r1 = 1'b1; e.d1 = 1'b1; e.ri1 = 3'(pi[q]); e.di1 = 3'(pj[q]);
        end
      end
      exp_q.push_back(e);
    end
  endfunction

  // Acceleration of the body at xi due to a unit mass at xj.
  function automatic real pair_acc(input real xi, input real xj);
    real d, ad;
    d  = xj - xi;
    ad = (d < 0.0) ? -d : d;
    if (ad == 0.0) return 1.0e6;
    return d / (ad * ad * ad);
  endfunction

  task automatic test_reset();
    rst   = '1;
    start = '0;
    repeat (3) @(posedge clk);
    #1 rst = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs[k] !== '0) begin
          errors++;
          $display("FAIL reset k%0d cycle %0d: got %h want 0", k, c, obs[k]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_pass(input int k);
    int   c = 0;
    obs_t e;
    build_trace(n_of(k), lat_of(k));
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1 start[k] = (c == 0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL pass k%0d cycle %0d: got %h want %h", k, c, obs[k], e);
      end
      c++;
    end
  endtask

  task automatic test_start_ignored();
    int   c = 0;
    int   len;
    obs_t e;
    len = trace_len(4, 1);
    build_trace(4, 1);
    exp_q.push_back('0);
    exp_q.push_back('0);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1 start[0] = (c == 0) || (c == 3) || (c == len - 1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL start_ignored cycle %0d: got %h want %h", c, obs[0], e);
      end
      c++;
    end
  endtask

  task automatic test_back_to_back();
    int   c = 0;
    int   len;
    obs_t e;
    len = trace_len(4, 1);
    build_trace(4, 1);
    build_trace(4, 1);
    exp_q.push_back('0);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1 start[0] = (c == 0) || (c == len);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", c, obs[0], e);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid_pass();
    int   c = 0;
    obs_t e;
    build_trace(4, 1);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    repeat (9) exp_q.push_back('0);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      start[0] = (c == 0);
      rst[0]   = (c == 3);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL reset_mid_pass cycle %0d: got %h want %h", c, obs[0], e);
      end
      c++;
    end
  endtask

  task automatic test_golden();
    real  x [4] = '{-2.0, -1.0, 1.0, 2.0};
    real  acc [4];
    real  opr0 [64], opd0 [64], opr1 [64], opd1 [64];
    real  want;
    int   c = 0;
    obs_t e, o;
    for (int i = 0; i < 4; i++) acc[i] = 0.0;
    build_trace(4, 1);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1 start[0] = (c == 0);
      @(negedge clk);
      o = obs[0];
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL golden_trace cycle %0d: got %h want %h", c, o, e);
      end
      // Array model: lane k yields OPR (accel on i) and OPD (accel on j) one cycle later.
      opr0[c] = o.v0 ? pair_acc(x[o.i0[1:0]], x[o.j0[1:0]]) : 0.0;
      opd0[c] = o.v0 ? pair_acc(x[o.j0[1:0]], x[o.i0[1:0]]) : 0.0;
      opr1[c] = o.v1 ? pair_acc(x[o.i1[1:0]], x[o.j1[1:0]]) : 0.0;
      opd1[c] = o.v1 ? pair_acc(x[o.j1[1:0]], x[o.i1[1:0]]) : 0.0;
      if (o.clr) for (int i = 0; i < 4; i++) acc[i] = 0.0;
      if (c >= 1) begin
        if (o.r0) acc[o.ri0[1:0]] += opr0[c-1];
        if (o.d0) acc[o.di0[1:0]] += opd0[c-1];
        if (o.r1) acc[o.ri1[1:0]] += opr1[c-1];
        if (o.d1) acc[o.di1[1:0]] += opd1[c-1];
      end
      c++;
    end
    for (int i = 0; i < 4; i++) begin
      want = 0.0;
      for (int j = 0; j < 4; j++) if (j != i) want += pair_acc(x[i], x[j]);
      checks++;
      if (acc[i] - want > 1.0e-9 || want - acc[i] > 1.0e-9) begin
        errors++;
        $display("FAIL golden a[%0d]: got %f want %f", i, acc[i], want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass(0);
    test_pass(1);
    test_pass(2);
    test_pass(3);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_pass();
    test_golden();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
